// File: rtl/seq_multdiv.sv
// Iterative signed multiply/divide unit with start/busy/valid handshake, abort,
// divide-by-zero fast path and a remainder output.
module seq_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic             abort,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             exception
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mag_op;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res;
    logic               neg_rem;

    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_signed;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quo_mag;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic               div_ovf;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        add_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_op : {WIDTH{1'b0}})};
        mul_next    = {add_sum, acc[WIDTH-1:1]};
        sub_diff    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_op};
        div_next    = sub_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_signed = neg_res ? -mul_next : mul_next;
        mul_ovf     = ~(&prod_signed[2*WIDTH-1:WIDTH-1]) & (|prod_signed[2*WIDTH-1:WIDTH-1]);
        quo_mag     = div_next[WIDTH-1:0];
        rem_mag     = div_next[2*WIDTH-1:WIDTH];
        quo_signed  = neg_res ? -quo_mag : quo_mag;
        rem_signed  = neg_rem ? -rem_mag : rem_mag;
        // only most-negative / -1 yields a positive quotient magnitude of 2^(WIDTH-1)
        div_ovf     = ~neg_res & quo_mag[WIDTH-1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            mag_op       <= '0;
            acc          <= '0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            remainder    <= '0;
            exception    <= 1'b0;
        end else if (abort) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    result_valid <= 1'b0;
                    count        <= '0;
                    if (start_mul) begin
                        state   <= MUL;
                        busy    <= 1'b1;
                        mag_op  <= magnitude(operand_a);
                        acc     <= {{WIDTH{1'b0}}, magnitude(operand_b)};
                        neg_res <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        neg_rem <= 1'b0;
                    end else if (start_div && operand_b == '0) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= '0;
                        remainder    <= '0;
                        exception    <= 1'b1;
                    end else if (start_div) begin
                        state   <= DIV;
                        busy    <= 1'b1;
                        mag_op  <= magnitude(operand_b);
                        acc     <= {{WIDTH{1'b0}}, magnitude(operand_a)};
                        neg_res <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        neg_rem <= operand_a[WIDTH-1];
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= prod_signed[WIDTH-1:0];
                        remainder    <= '0;
                        exception    <= mul_ovf;
                    end
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= quo_signed;
                        remainder    <= rem_signed;
                        exception    <= div_ovf;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
